// File: rtl/sha256_nonce_sched_if.sv
// Core job bus and result stream of the nonce scheduler.
// master = scheduler, slave = core plus result consumer.
interface sha256_nonce_sched_if;
    logic              core_start;
    logic              core_new_hashes;
    logic [15:0][31:0] core_message;
    logic [7:0][31:0]  core_in;
    logic [7:0][31:0]  core_sha;
    logic              core_done;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_nonce;
    logic [7:0][31:0]  res_hash;

    modport master (
        output core_start, core_new_hashes, core_message, core_in,
        input  core_sha, core_done,
        output res_valid, res_nonce, res_hash,
        input  res_ready
    );

    modport slave (
        input  core_start, core_new_hashes, core_message, core_in,
        output core_sha, core_done,
        input  res_valid, res_nonce, res_hash,
        output res_ready
    );
endinterface

// File: rtl/sha256_nonce_sched.sv
// Bitcoin double-SHA256 nonce scheduler: hashes the header midstate once,
// then runs two core jobs per nonce and streams {nonce, digest} results.
module sha256_nonce_sched #(
    parameter int NUM_NONCES = 16,
    parameter int CNT_W      = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [19:0][31:0]    header,
    input  logic [31:0]          nonce_base,
    sha256_nonce_sched_if.master bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [3:0] {
        IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT,
        P3_GO, P3_WAIT, EMIT, FIN
    } state_t;

    state_t            state, state_d;
    logic [31:0]       cur_nonce;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [7:0][31:0]  mid, h1buf;
    logic [15:0][31:0] p2_msg, p3_msg;
    logic              seen_busy, complete;
    logic              handshake, last;
    logic              unused_nonce_field;

    assign unused_nonce_field = ^header[19];
    assign cnt_inc   = cnt + CNT_W'(1);
    assign last      = (cnt_inc == CNT_W'(NUM_NONCES));
    assign complete  = bus.core_done & seen_busy;
    assign handshake = bus.res_valid & bus.res_ready;
    assign busy      = (state != IDLE);

    // Padded second header block and padded 32-byte digest block
    always_comb begin
        p2_msg      = '0;
        p2_msg[0]   = header[16];
        p2_msg[1]   = header[17];
        p2_msg[2]   = header[18];
        p2_msg[3]   = cur_nonce;
        p2_msg[4]   = 32'h8000_0000;
        p2_msg[15]  = 32'd640;
        p3_msg      = '0;
        p3_msg[7:0] = h1buf;
        p3_msg[8]   = 32'h8000_0000;
        p3_msg[15]  = 32'd256;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = P1_GO;
            P1_GO:   if (bus.core_done) state_d = P1_WAIT;
            P1_WAIT: if (complete) state_d = P2_GO;
            P2_GO:   if (bus.core_done) state_d = P2_WAIT;
            P2_WAIT: if (complete) state_d = P3_GO;
            P3_GO:   if (bus.core_done) state_d = P3_WAIT;
            P3_WAIT: if (complete) state_d = EMIT;
            EMIT:    if (handshake) state_d = last ? FIN : P2_GO;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            cur_nonce           <= '0;
            cnt                 <= '0;
            mid                 <= '0;
            h1buf               <= '0;
            seen_busy           <= 1'b0;
            done                <= 1'b0;
            bus.core_start      <= 1'b0;
            bus.core_new_hashes <= 1'b0;
            bus.core_message    <= '0;
            bus.core_in         <= '0;
            bus.res_valid       <= 1'b0;
            bus.res_nonce       <= '0;
            bus.res_hash        <= '0;
        end else begin
            state          <= state_d;
            done           <= (state_d == FIN);
            bus.core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur_nonce <= nonce_base;
                        cnt       <= '0;
                    end
                end
                P1_GO: begin
                    if (bus.core_done) begin
                        bus.core_start      <= 1'b1;
                        bus.core_new_hashes <= 1'b0;
                        bus.core_message    <= header[15:0];
                        seen_busy           <= 1'b0;
                    end
                end
                P2_GO: begin
                    if (bus.core_done) begin
                        bus.core_start      <= 1'b1;
                        bus.core_new_hashes <= 1'b1;
                        bus.core_in         <= mid;
                        bus.core_message    <= p2_msg;
                        seen_busy           <= 1'b0;
                    end
                end
                P3_GO: begin
                    if (bus.core_done) begin
                        bus.core_start      <= 1'b1;
                        bus.core_new_hashes <= 1'b0;
                        bus.core_message    <= p3_msg;
                        seen_busy           <= 1'b0;
                    end
                end
                // done is still high on the start cycle; wait for it to drop
                P1_WAIT: begin
                    if (!bus.core_done) seen_busy <= 1'b1;
                    else if (seen_busy) mid <= bus.core_sha;
                end
                P2_WAIT: begin
                    if (!bus.core_done) seen_busy <= 1'b1;
                    else if (seen_busy) h1buf <= bus.core_sha;
                end
                P3_WAIT: begin
                    if (!bus.core_done) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        bus.res_hash  <= bus.core_sha;
                        bus.res_nonce <= cur_nonce;
                        bus.res_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        bus.res_valid <= 1'b0;
                        cur_nonce     <= cur_nonce + 32'd1;
                        cnt           <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sha256_nonce_sched.md
Name: sha256_nonce_sched

Overview:
- Controller that time-shares one simplified_sha256 core to compute Bitcoin double-SHA256 over an 80-byte header for NUM_NONCES consecutive nonces.
- Runs block 1 (midstate) once, then per nonce: block 2 chained from the midstate, then a single-block hash of the 256-bit digest.
- Streams {nonce, H0..H7} results through a valid/ready handshake.
- Sits between the top-level miner FSM and the sha core instance.

Parameters:
NUM_NONCES, 16, nonces processed per start (1..2^16).
CNT_W, 17, nonce counter width; must be at least clog2(NUM_NONCES)+1.

Ports:
clk  in  1  clock, all logic on posedge.
reset_n  in  1  reset; asynchronous, active-low.
start  in  1  begin job; sampled only in IDLE.
header  in  32x20  header words 0..19 as big-endian words; word 19 (nonce field) ignored. Must be stable from start until done.
nonce_base  in  32  first nonce word; captured on accepted start.
core_start  out  1  to core start.
core_new_hashes  out  1  0 = core uses IV, 1 = core uses core_in.
core_message  out  32x16  to core message.
core_in  out  32x8  to core chaining input.
core_sha  in  32x8  core digest.
core_done  in  1  core idle flag; high in core IDLE.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts.
res_nonce  out  32  nonce of the result.
res_hash  out  32x8  final double-SHA digest H0..H7.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last result handshakes.

Behaviour:
- Reset (async, any state): state=IDLE; core_start=0, core_new_hashes=0, res_valid=0, done=0, busy=0. core_message, core_in, res_hash and res_nonce reset to 0. Counters and midstate reset to 0.
- States: IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, P3_GO, P3_WAIT, EMIT, FIN.
- IDLE: on start=1, capture nonce_base into cur_nonce, clear cnt, go to P1_GO. start while not IDLE is ignored.
- Core handshake (every *_GO / *_WAIT pair):
  - *_GO waits for core_done=1, then asserts core_start for exactly 1 cycle, clears seen_busy and moves to *_WAIT.
  - core_message, core_in and core_new_hashes are registered in *_GO and held constant through *_WAIT.
  - *_WAIT sets seen_busy when core_done=0. Completion is core_done=1 with seen_busy=1, so the stale done level from the start cycle is never taken as completion.
  - core_sha is sampled on the completion cycle.
- P1 (block 1): message = header[0..15], new_hashes=0. On completion, mid[0..7] <= core_sha, go to P2_GO.
- P2 (block 2): new_hashes=1, core_in = mid. Message:
  - w0..w2 = header[16..18], w3 = cur_nonce, w4 = 32'h80000000, w5..w14 = 0, w15 = 32'd640.
  - On completion, h1buf <= core_sha, go to P3_GO.
- P3 (second hash): new_hashes=0. Message:
  - w0..w7 = h1buf, w8 = 32'h80000000, w9..w14 = 0, w15 = 32'd256.
  - On completion, res_hash <= core_sha, res_nonce <= cur_nonce, res_valid <= 1, go to EMIT.
- EMIT: hold res_valid and data stable until res_valid & res_ready (any number of stall cycles). On the handshake cycle:
  - res_valid <= 0, cur_nonce <= cur_nonce+1 (mod 2^32), cnt <= cnt+1.
  - If cnt+1 == NUM_NONCES go to FIN, else go to P2_GO (the midstate is reused; P1 is not rerun).
- FIN: done=1 for one cycle, then IDLE. A start on the FIN cycle is ignored.
- Nonce wrap: nonce_base=32'hFFFFFFFF gives 32'hFFFFFFFF then 32'h00000000; no flag is raised.
- Core cost: 1 + 2*NUM_NONCES core jobs per start. With a 69-cycle core and res_ready tied high, one nonce takes about 140 cycles.
- res_ready held low indefinitely stalls the scheduler in EMIT. The core stays idle and no result is dropped or overwritten.

Test Plan:
- Reset mid-P2_WAIT (drop reset_n between clock edges) -> outputs zero immediately, without waiting for a clock edge. Restart after release completes normally with correct hashes.
- Genesis header (header[0..18] big-endian words of the 80-byte genesis header), nonce_base=32'h1dac2b7c, NUM_NONCES=1 -> one result with res_nonce=32'h1dac2b7c, res_hash[0]=32'h6fe28c0a, res_hash[7]=32'h00000000. Exactly 3 core_start pulses; done pulses once.
- NUM_NONCES=16, res_ready=1, random header, nonce_base=0 -> 16 results, nonces 0..15 in order. Every res_hash matches the golden double-SHA model. Exactly 33 core_start pulses; the core_in of every P2 equals the P1 digest.
- res_ready low for 200 cycles at result 3 -> res_valid, res_hash and res_nonce stay stable; no core_start pulses during the stall; results 3..15 still correct afterwards.
- nonce_base=32'hFFFFFFFE, NUM_NONCES=4 -> res_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, each hash matching the model.
- start pulsed during P2_WAIT and during FIN -> ignored: the result count and nonce sequence are unchanged and there is no extra core_start.
